// File: rtl/jt12_rst_pkg.sv
// Shared definitions for the jt12 reset sequencer: state encoding and
// default register-clear constants.
package jt12_rst_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2,
    ST_RUN   = 2'd3
  } rst_state_e;

  // Pan registers power up with both output channels enabled.
  localparam logic [7:0] PAN_BASE_DEF = 8'hB4;
  localparam logic [7:0] PAN_VAL_DEF  = 8'hC0;

endpackage

// File: rtl/jt12_rst_hold.sv
// Reset hold counter: counts cen pulses while enabled and flags the pulse
// that completes the minimum hold time.
module jt12_rst_hold #(
  parameter int CNTW     = 5,
  parameter int HOLD_CYC = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic cen,
  output logic tc
);

  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && cen) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Terminal count is the cen pulse that takes the count to HOLD_CYC.
  assign tc = !clr && en && cen && (cnt_q == CNTW'(HOLD_CYC - 1));

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/jt12_rst_seq.sv
// Reset sequencer for the FM core: holds both reset domains, releases the
// clock-enable domain, clears the register file, then releases the core.
module jt12_rst_seq
  import jt12_rst_pkg::*;
#(
  parameter int             AW       = 8,
  parameter int             DW       = 8,
  parameter int             HOLD_CYC = 16,
  parameter int             CNTW     = 5,
  parameter logic [AW-1:0]  PAN_BASE = AW'(PAN_BASE_DEF),
  parameter logic [DW-1:0]  PAN_VAL  = DW'(PAN_VAL_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          soft_rst,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_din,
  output logic          rst_clkgen,
  output logic          rst_core,
  output logic          busy,
  output logic          host_wait,
  output logic          reg_we,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_din
);

  rst_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rst_clkgen_q, rst_clkgen_d;
  logic          rst_core_q, rst_core_d;
  logic          busy_q, busy_d;
  logic          reg_we_q, reg_we_d;
  logic [AW-1:0] reg_addr_q, reg_addr_d;
  logic [DW-1:0] reg_din_q, reg_din_d;

  logic any_rst;
  logic hold_tc;
  logic is_pan;
  logic walk_last;

  assign any_rst = rst | soft_rst;

  jt12_rst_hold #(
    .CNTW     (CNTW),
    .HOLD_CYC (HOLD_CYC)
  ) u_hold (
    .clk (clk),
    .clr (any_rst),
    .en  (state_q == ST_HOLD),
    .cen (cen),
    .tc  (hold_tc)
  );

  // Wrapping subtraction keeps the pan window test a single compare.
  assign is_pan    = (addr_q - PAN_BASE) < AW'(3);
  assign walk_last = (addr_q == {AW{1'b1}});

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rst_clkgen_d = rst_clkgen_q;
    rst_core_d   = rst_core_q;
    busy_d       = busy_q;
    reg_we_d     = reg_we_q;
    reg_addr_d   = reg_addr_q;
    reg_din_d    = reg_din_q;

    if (any_rst) begin
      state_d      = ST_HOLD;
      addr_d       = '0;
      rst_clkgen_d = 1'b1;
      rst_core_d   = 1'b1;
      busy_d       = 1'b1;
      reg_we_d     = 1'b0;
      reg_addr_d   = '0;
      reg_din_d    = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          reg_we_d = 1'b0;
          if (hold_tc) begin
            state_d      = ST_CLEAR;
            rst_clkgen_d = 1'b0;
          end
        end
        ST_CLEAR: begin
          reg_we_d   = 1'b1;
          reg_addr_d = addr_q;
          reg_din_d  = is_pan ? PAN_VAL : '0;
          addr_d     = addr_q + 1'b1;
          if (walk_last) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          reg_we_d   = 1'b0;
          rst_core_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = ST_RUN;
        end
        default: begin
          // Host owns the port; data and address only move on a write.
          reg_we_d = host_we;
          if (host_we) begin
            reg_addr_d = host_addr;
            reg_din_d  = host_din;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    addr_q       <= addr_d;
    rst_clkgen_q <= rst_clkgen_d;
    rst_core_q   <= rst_core_d;
    busy_q       <= busy_d;
    reg_we_q     <= reg_we_d;
    reg_addr_q   <= reg_addr_d;
    reg_din_q    <= reg_din_d;
  end

  assign rst_clkgen = rst_clkgen_q;
  assign rst_core   = rst_core_q;
  assign busy       = busy_q;
  assign host_wait  = busy_q;
  assign reg_we     = reg_we_q;
  assign reg_addr   = reg_addr_q;
  assign reg_din    = reg_din_q;

endmodule
